// File: rtl/cpu_mul_pkg.sv
// Shared definitions for the multiply sequencer:
// op encodings, FSM states and pass counter sizing.
package cpu_mul_pkg;

    localparam int CELL_LAT_DEF = 1;
    localparam int PASS_CNT_W   = 2;
    localparam int TAG_W        = PASS_CNT_W;

    localparam logic [1:0] MUL_OP_MUL    = 2'd0;
    localparam logic [1:0] MUL_OP_MULXUU = 2'd1;
    localparam logic [1:0] MUL_OP_MULXSU = 2'd2;
    localparam logic [1:0] MUL_OP_MULXSS = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_FIX,
        ST_DONE
    } mul_state_e;

    // Index of the final pass: one pass for MUL, four for MULX.
    function automatic logic [PASS_CNT_W-1:0] pass_last(
        input logic [1:0] op
    );
        return (op == MUL_OP_MUL) ? PASS_CNT_W'(0) : PASS_CNT_W'(3);
    endfunction

endpackage

// File: rtl/cpu_mul_tag_pipe.sv
// Return-tag delay line: carries {valid,k} alongside
// the mult cell so each product is matched to its pass.
module cpu_mul_tag_pipe
    import cpu_mul_pkg::*;
#(
    parameter int DEPTH = CELL_LAT_DEF,
    parameter int W     = TAG_W
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         in_valid,
    input  logic [W-1:0] in_tag,
    output logic         out_valid,
    output logic [W-1:0] out_tag
);

    logic [DEPTH-1:0] vld;
    logic [W-1:0]     tag [DEPTH];

    // Shift valid/tag one stage per clock; clear drops all in flight.
    always_ff @(posedge clk) begin
        if (clear) begin
            vld <= '0;
            for (int i = 0; i < DEPTH; i++) tag[i] <= '0;
        end else begin
            vld[0] <= in_valid;
            tag[0] <= in_tag;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                tag[i] <= tag[i-1];
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_tag   = tag[DEPTH-1];

endmodule

// File: rtl/cpu_mul_seq.sv
// Multiply sequencer in front of the CPU mult cell:
// MUL low word directly, MULX high word from four 16x16 passes.
module cpu_mul_seq
    import cpu_mul_pkg::*;
#(
    parameter int CELL_LAT = CELL_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_src1,
    input  logic [31:0] req_src2,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [31:0] cell_src1,
    output logic [31:0] cell_src2,
    input  logic [31:0] cell_result
);

    mul_state_e            state;
    mul_state_e            nxt;
    logic                  rdy_q;
    logic [1:0]            op_q;
    logic [31:0]           a_q;
    logic [31:0]           b_q;
    logic [PASS_CNT_W-1:0] k_q;
    logic [PASS_CNT_W-1:0] last;
    logic [63:0]           acc;
    logic                  iss_valid;
    logic [PASS_CNT_W-1:0] iss_k;
    logic                  ret_valid;
    logic [PASS_CNT_W-1:0] ret_k;
    logic [31:0]           pass_a;
    logic [31:0]           pass_b;
    logic [31:0]           fix_hi;
    logic                  accept;

    assign req_ready = rdy_q;
    assign rsp_valid = (state == ST_DONE);
    assign accept    = req_valid && rdy_q;
    assign last      = pass_last(op_q);

    // Next-state sequencing of one multiply op.
    always_comb begin
        nxt = state;
        unique case (state)
            ST_IDLE:  if (accept) nxt = ST_ISSUE;
            ST_ISSUE: if (k_q == last) nxt = ST_WAIT;
            ST_WAIT:  if (ret_valid && ret_k == last) nxt = ST_FIX;
            ST_FIX:   nxt = ST_DONE;
            ST_DONE:  if (rsp_ready) nxt = ST_IDLE;
            default:  nxt = ST_IDLE;
        endcase
    end

    // Operand selection for the current pass.
    always_comb begin
        pass_a = a_q;
        pass_b = b_q;
        if (op_q != MUL_OP_MUL) begin
            unique case (k_q)
                2'd0: begin
                    pass_a = {16'h0, a_q[15:0]};
                    pass_b = {16'h0, b_q[15:0]};
                end
                2'd1: begin
                    pass_a = {16'h0, a_q[15:0]};
                    pass_b = {16'h0, b_q[31:16]};
                end
                2'd2: begin
                    pass_a = {16'h0, a_q[31:16]};
                    pass_b = {16'h0, b_q[15:0]};
                end
                default: begin
                    pass_a = {16'h0, a_q[31:16]};
                    pass_b = {16'h0, b_q[31:16]};
                end
            endcase
        end
    end

    // Signed correction of the unsigned high word.
    always_comb begin
        fix_hi = acc[63:32];
        if ((op_q == MUL_OP_MULXSU || op_q == MUL_OP_MULXSS) && a_q[31])
            fix_hi = fix_hi - b_q;
        if (op_q == MUL_OP_MULXSS && b_q[31])
            fix_hi = fix_hi - a_q;
    end

    // State register; ready is registered so it stays low through reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            rdy_q <= 1'b0;
        end else begin
            state <= nxt;
            rdy_q <= (nxt == ST_IDLE);
        end
    end

    // Datapath: operand capture, pass issue, product accumulate, result.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q       <= MUL_OP_MUL;
            a_q        <= '0;
            b_q        <= '0;
            k_q        <= '0;
            acc        <= '0;
            cell_src1  <= '0;
            cell_src2  <= '0;
            iss_valid  <= 1'b0;
            iss_k      <= '0;
            rsp_result <= '0;
        end else begin
            if (accept) begin
                op_q <= req_op;
                a_q  <= req_src1;
                b_q  <= req_src2;
                k_q  <= '0;
                acc  <= '0;
            end
            iss_valid <= (state == ST_ISSUE);
            iss_k     <= k_q;
            cell_src1 <= (state == ST_ISSUE) ? pass_a : 32'h0;
            cell_src2 <= (state == ST_ISSUE) ? pass_b : 32'h0;
            if (state == ST_ISSUE && k_q != last)
                k_q <= k_q + PASS_CNT_W'(1);
            if (ret_valid) begin
                if (op_q == MUL_OP_MUL) begin
                    acc[31:0] <= cell_result;
                end else begin
                    unique case (ret_k)
                        2'd0:    acc <= acc + {32'h0, cell_result};
                        2'd3:    acc <= acc + {cell_result, 32'h0};
                        default: acc <= acc + {16'h0, cell_result, 16'h0};
                    endcase
                end
            end
            if (state == ST_FIX) begin
                acc[63:32] <= fix_hi;
                rsp_result <= (op_q == MUL_OP_MUL) ? acc[31:0] : fix_hi;
            end
        end
    end

    cpu_mul_tag_pipe #(
        .DEPTH (CELL_LAT),
        .W     (PASS_CNT_W)
    ) u_tag_pipe (
        .clk       (clk),
        .clear     (reset),
        .in_valid  (iss_valid),
        .in_tag    (iss_k),
        .out_valid (ret_valid),
        .out_tag   (ret_k)
    );

endmodule

// File: tb/tb_cpu_mul_seq.sv
// Directed bench for cpu_mul_seq with a one-stage
// registered mult cell model on the cell_* ports.
module tb_cpu_mul_seq;
    import cpu_mul_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_src1;
    logic [31:0] req_src2;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [31:0] cell_src1;
    logic [31:0] cell_src2;
    logic [31:0] cell_result;
    logic [31:0] cell_q;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Mult cell: registered product, unregistered output.
    always_ff @(posedge clk) cell_q <= cell_src1 * cell_src2;
    assign cell_result = cell_q;

    cpu_mul_seq #(.CELL_LAT(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_src1    (req_src1),
        .req_src2    (req_src2),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .cell_src1   (cell_src1),
        .cell_src2   (cell_src2),
        .cell_result (cell_result)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Clocks after the accept edge until rsp_valid; 0 on timeout.
    task automatic wait_rsp(output int n);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic consume(input string nm);
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk({nm, "_vld_drop"}, 32'(rsp_valid), 32'd0);
        chk({nm, "_rdy_back"}, 32'(req_ready), 32'd1);
    endtask

    task automatic run_op(input string nm, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat);
        int n;
        @(negedge clk);
        req_op    = op;
        req_src1  = a;
        req_src2  = b;
        req_valid = 1'b1;
        chk({nm, "_rdy"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_rsp(n);
        chk({nm, "_lat"}, 32'(n), 32'(lat));
        chk({nm, "_res"}, rsp_result, exp);
        consume(nm);
    endtask

    int n;

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_src1  = '0;
        req_src2  = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy",   32'(req_ready), 32'd0);
        chk("rst_vld",   32'(rsp_valid), 32'd0);
        chk("rst_res",   rsp_result, 32'd0);
        chk("rst_src1",  cell_src1, 32'd0);
        chk("rst_src2",  cell_src2, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_rdy", 32'(req_ready), 32'd1);

        run_op("mul7x6",  MUL_OP_MUL,    32'd7, 32'd6, 32'h0000002A, 4);
        run_op("uu_ff",   MUL_OP_MULXUU, 32'hFFFFFFFF, 32'hFFFFFFFF,
               32'hFFFFFFFE, 7);
        run_op("ss_8000", MUL_OP_MULXSS, 32'h80000000, 32'h80000000,
               32'h40000000, 7);
        run_op("ss_ff",   MUL_OP_MULXSS, 32'hFFFFFFFF, 32'hFFFFFFFF,
               32'h00000000, 7);
        run_op("su_ff",   MUL_OP_MULXSU, 32'hFFFFFFFF, 32'hFFFFFFFF,
               32'hFFFFFFFF, 7);
        run_op("su_2x8",  MUL_OP_MULXSU, 32'h00000002, 32'h80000000,
               32'h00000001, 7);
        run_op("uu_mix",  MUL_OP_MULXUU, 32'h12345678, 32'h9ABCDEF0,
               32'h0B00EA4E, 7);
        run_op("mul_big", MUL_OP_MUL,    32'h12345678, 32'h9ABCDEF0,
               32'h242D2080, 4);

        // Backpressure with a queued request.
        @(negedge clk);
        req_op    = MUL_OP_MUL;
        req_src1  = 32'd9;
        req_src2  = 32'd9;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_src1 = 32'd4;
        req_src2 = 32'd4;
        wait_rsp(n);
        chk("bp_lat", 32'(n), 32'd4);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_vld", 32'(rsp_valid), 32'd1);
            chk("bp_hold_res", rsp_result, 32'd81);
            chk("bp_hold_rdy", 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("bp_vld_drop", 32'(rsp_valid), 32'd0);
        chk("bp_idle_rdy", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("bp_q_taken", 32'(req_ready), 32'd0);
        wait_rsp(n);
        chk("bp_q_lat", 32'(n), 32'd4);
        chk("bp_q_res", rsp_result, 32'd16);
        consume("bp_q");

        // Reset during WAIT of a MULXUU.
        @(negedge clk);
        req_op    = MUL_OP_MULXUU;
        req_src1  = 32'hFFFFFFFF;
        req_src2  = 32'hFFFFFFFF;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_rdy", 32'(req_ready), 32'd0);
        chk("mid_rst_vld", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) n++;
        end
        chk("abandon_vld", 32'(n), 32'd0);
        run_op("mul3x5", MUL_OP_MUL, 32'd3, 32'd5, 32'h0000000F, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
